// File: rtl/sigmoid_backward_if.sv
// Handshake bundle for sigmoid_backward: input (y, dL/dy) stream and output dL/da stream.
interface sigmoid_backward_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y_in;
   logic [WIDTH-1:0] grad_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] grad_out;

   modport master (
      output in_valid, y_in, grad_in, out_ready,
      input  in_ready, out_valid, grad_out
   );

   modport slave (
      input  in_valid, y_in, grad_in, out_ready,
      output in_ready, out_valid, grad_out
   );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass dL/da = dL/dy * y*(1-y), 3-stage whole-pipe-stall pipeline, Q(WIDTH-FL).FL.
// Optional macro SIGMOID_BWD_CLAMP_EN clamps y to [0,ONE] in stage 1.
module sigmoid_backward #(
   parameter int WIDTH = 32,
   parameter int FL    = 24
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   sigmoid_backward_if.slave bus
);

   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(longint'(1) << FL);

   logic                    advance;

   logic                    v1;
   logic                    v2;
   logic                    v3;
   logic signed [WIDTH-1:0] y1;
   logic signed [WIDTH-1:0] om1;
   logic signed [WIDTH-1:0] g1;
   logic signed [WIDTH-1:0] d2;
   logic signed [WIDTH-1:0] g2;
   logic signed [WIDTH-1:0] g3;

   logic signed [WIDTH-1:0]   y_s;
   logic signed [WIDTH-1:0]   y_c;
   logic signed [WIDTH-1:0]   om_c;
   logic signed [2*WIDTH-1:0] p_d;
   logic signed [2*WIDTH-1:0] p_g;
   logic signed [WIDTH-1:0]   d_next;
   logic signed [WIDTH-1:0]   g_next;

   assign advance       = en & (~v3 | bus.out_ready);
   assign bus.in_ready  = advance & ~rst;
   assign bus.out_valid = v3;
   assign bus.grad_out  = g3;

   assign y_s = bus.y_in;

   always_comb begin
      y_c = y_s;
`ifdef SIGMOID_BWD_CLAMP_EN
      if (y_s < 0)
         y_c = '0;
      else if (y_s > ONE)
         y_c = ONE;
`endif
      om_c = ONE - y_c;
   end

   // Arithmetic shift of the full product equals taking bits [FL+WIDTH-1:FL] (floor toward -inf).
   always_comb begin
      p_d    = y1 * om1;
      p_g    = g2 * d2;
      d_next = WIDTH'(p_d >>> FL);
      g_next = WIDTH'(p_g >>> FL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         y1  <= '0;
         om1 <= '0;
         g1  <= '0;
         d2  <= '0;
         g2  <= '0;
         g3  <= '0;
      end else if (advance) begin
         v1  <= bus.in_valid;
         y1  <= y_c;
         om1 <= om_c;
         g1  <= bus.grad_in;
         v2  <= v1;
         d2  <= d_next;
         g2  <= g1;
         v3  <= v2;
         g3  <= g_next;
      end
   end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed self-checking bench for sigmoid_backward: single vectors, streaming with stalls, reset flush.
module tb_sigmoid_backward;

   logic clk = 1'b0;
   logic rst;
   logic en;

   int n_checks = 0;
   int n_fail   = 0;

   sigmoid_backward_if #(.WIDTH(32)) bus ();

   sigmoid_backward #(.WIDTH(32), .FL(24)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_single(input string tag, input logic [31:0] y, input logic [31:0] g,
                             input logic [31:0] exp);
      bus.in_valid  = 1'b1;
      bus.y_in      = y;
      bus.grad_in   = g;
      bus.out_ready = 1'b1;
      en            = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check(tag, bus.grad_out, exp);
      @(posedge clk); @(negedge clk);
      check({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
   endtask

   logic [31:0] s_y   [8] = '{32'h00800000, 32'h00400000, 32'h00800000, 32'h00400000,
                              32'h00800000, 32'h00C00000, 32'h00800000, 32'h00400000};
   logic [31:0] s_g   [8] = '{32'h01000000, 32'h01000000, 32'h02000000, 32'h02000000,
                              32'hFF000000, 32'h01000000, 32'h00400000, 32'hFC000000};
   logic [31:0] s_exp [8] = '{32'h00400000, 32'h00300000, 32'h00800000, 32'h00600000,
                              32'hFFC00000, 32'h00300000, 32'h00100000, 32'hFF400000};

   initial begin
      int iidx;
      int oidx;

      rst           = 1'b1;
      en            = 1'b1;
      bus.in_valid  = 1'b1;
      bus.y_in      = 32'h00800000;
      bus.grad_in   = 32'h01000000;
      bus.out_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_grad_out", bus.grad_out, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);

      run_single("half_pos", 32'h00800000, 32'h01000000, 32'h00400000);
      run_single("half_neg", 32'h00800000, 32'hFE000000, 32'hFF800000);
      run_single("y_zero",   32'h00000000, 32'h01000000, 32'h00000000);
      run_single("y_one",    32'h01000000, 32'h01000000, 32'h00000000);
      run_single("y_lsb",    32'h00000001, 32'h01000000, 32'h00000000);
`ifdef SIGMOID_BWD_CLAMP_EN
      run_single("y_over", 32'h01800000, 32'h01000000, 32'h00000000);
      run_single("y_neg",  32'hFFFFFFFF, 32'h01000000, 32'h00000000);
`else
      run_single("y_over", 32'h01800000, 32'h01000000, 32'hFF400000);
      run_single("y_neg",  32'hFFFFFFFF, 32'h01000000, 32'hFFFFFFFE);
`endif

      // Stream: out_ready low in cycles 4-6, en low in cycles 9-10.
      iidx = 0;
      oidx = 0;
      for (int cyc = 0; cyc < 60 && oidx < 8; cyc++) begin
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         en            = !(cyc == 9 || cyc == 10);
         if (iidx < 8) begin
            bus.in_valid = 1'b1;
            bus.y_in     = s_y[iidx];
            bus.grad_in  = s_g[iidx];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.out_valid)
            check("stream_data", bus.grad_out, s_exp[oidx]);
         if (bus.out_valid && !bus.out_ready)
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         if (!en)
            check("en_in_ready", 32'(bus.in_ready), 32'd0);
         if (en && bus.out_ready)
            check("flow_in_ready", 32'(bus.in_ready), 32'd1);
         if (bus.out_valid && bus.out_ready && en)
            oidx++;
         if (bus.in_valid && bus.in_ready)
            iidx++;
         @(posedge clk); @(negedge clk);
      end
      check("stream_count", 32'(oidx), 32'd8);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      en            = 1'b1;
      @(negedge clk); @(negedge clk);

      // Reset flush with three samples in flight.
      bus.in_valid = 1'b1;
      bus.y_in     = 32'h00800000;
      bus.grad_in  = 32'h01000000;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_grad_out", bus.grad_out, 32'd0);
      check("flush_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("no_stale", 32'(bus.out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
